rib_ex_bridge: RTL and testbench
================================

Name: rib_ex_bridge

Overview:
- Sits directly downstream of the core's execute-stage memory port (rib_ex_*) and adapts it to a wait-stated valid/ready peripheral bus.
- The core's port expects read data in the same cycle; this block asserts a hold flag into the core's hold input until the slave responds.
- It then presents the registered read data for exactly one cycle with hold released, so the execute stage retires the access.

Parameters:
- ADDR_W, 32, address width (matches the core memory address bus)
- DATA_W, 32, data width (matches the core memory data bus)
- TIMEOUT_CYCLES, 255, maximum number of ACCESS-state cycles before abort; used only with the timeout feature; must be ≥1

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- ex_addr_i  in  ADDR_W  address from the core's execute port
- ex_data_i  in  DATA_W  write data from the core
- ex_req_i  in  1  access request from the core
- ex_we_i  in  1  write enable from the core
- ex_data_o  out  DATA_W  read data returned to the core
- hold_o  out  1  pipeline hold, driven to the core's bus-hold input
- m_valid_o  out  1  slave request valid
- m_ready_i  in  1  slave accepts / completes the request
- m_addr_o  out  ADDR_W  registered slave address
- m_wdata_o  out  DATA_W  registered slave write data
- m_we_o  out  1  registered slave write enable
- m_rdata_i  in  DATA_W  slave read data, valid when m_valid_o && m_ready_i
- err_o  out  1  one-cycle pulse on timeout abort (tied 0 without the feature)

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; m_valid_o=0, m_addr_o=0, m_wdata_o=0, m_we_o=0; rdata register=0; timeout counter=0; err_o=0. Consequently hold_o=0 and ex_data_o=0.
- States: IDLE, ACCESS, DONE. Two-bit encoding.
- IDLE:
  - hold_o = ex_req_i (combinational, so the core stalls in the same cycle it requests).
  - If ex_req_i=1: register ex_addr_i, ex_data_i and ex_we_i into m_addr_o, m_wdata_o and m_we_o; set m_valid_o=1; go to ACCESS.
- ACCESS:
  - hold_o=1; m_valid_o=1; m_addr_o, m_wdata_o and m_we_o are stable.
  - On m_valid_o && m_ready_i: capture m_rdata_i into the rdata register (captured for writes too; the value is don't-care); clear m_valid_o; go to DONE.
- DONE:
  - hold_o=0; ex_data_o = rdata register; the core retires the access at this clock edge.
  - Next state is IDLE unconditionally. A new request is seen in IDLE on the following cycle.
- ex_data_o = rdata register in every state. Only the DONE cycle is architecturally consumed.
- Minimum latency, with m_ready_i=1 on the first valid cycle: request cycle (IDLE) + 1 ACCESS cycle + DONE = 3 cycles, hold_o high for 2 of them.
- m_valid_o is never withdrawn before m_ready_i, and the m_* bus payload never changes while valid.
- ex_req_i dropping during ACCESS (flush/jump/interrupt):
  - The slave transaction still completes and the FSM still passes through DONE.
  - hold_o stays 1 in ACCESS regardless of ex_req_i.
  - The result is discarded by the core.
- ex_* inputs are ignored outside IDLE.
- Reset asserted mid-ACCESS: all state is cleared immediately; m_valid_o drops asynchronously and the slave sees the transaction abandoned.
- There are no back-to-back requests without an IDLE cycle; throughput is at most one access per 3 cycles.

Optional Feature:
- Macro: RIB_EX_BRIDGE_TIMEOUT_EN.
- Defined:
  - An 8-bit (clog2 of TIMEOUT_CYCLES+1) counter clears on IDLE→ACCESS and increments each ACCESS cycle without m_ready_i.
  - When the count reaches TIMEOUT_CYCLES with m_ready_i=0: clear m_valid_o, load the rdata register with 0, pulse err_o=1 for one cycle (registered, coincident with DONE), go to DONE.
  - A ready arriving on the same cycle the count reaches its limit wins: normal completion, no err_o.
- Undefined: no counter; ACCESS waits indefinitely; err_o is constant 0.

Decomposition:
- Shared package/defines file holds:
  - state encodings RIB_EX_BR_IDLE=2'd0, RIB_EX_BR_ACCESS=2'd1, RIB_EX_BR_DONE=2'd2
  - default widths, reusing the existing memory address/data bus width macros
- Single module. No sub-module needed; the timeout counter is inline under the macro.

Test Plan:
- Read, zero wait (m_ready_i=1 constant): ex_req_i=1, we=0, addr=0x1000_0004, slave rdata=0xCAFE_F00D.
  - m_valid_o high 1 cycle; hold_o high 2 cycles, then 0 with ex_data_o=0xCAFE_F00D in the DONE cycle.
- Write, 5 wait states: addr=0x2000_0000, data=0x1234_5678, we=1, m_ready_i asserted on the 6th valid cycle.
  - m_addr_o, m_wdata_o and m_we_o are stable across all 6 cycles.
  - hold_o high 7 cycles total.
- Request dropped mid-ACCESS: ex_req_i falls after 1 cycle in ACCESS, ready after 3.
  - m_valid_o held until ready; FSM returns IDLE via DONE; no spurious second transaction.
- Async reset mid-ACCESS: rst=0 pulse between edges during the wait.
  - m_valid_o and hold_o go 0 immediately; state=IDLE; ex_data_o=0.
- With RIB_EX_BRIDGE_TIMEOUT_EN, TIMEOUT_CYCLES=4, m_ready_i=0 forever:
  - valid for 4 cycles, then err_o=1 for one cycle with ex_data_o=0 and hold_o=0.
  - Repeat with ready on cycle 4: normal data returned, err_o=0.
- Back-to-back: ex_req_i held high across two accesses (0xAAAA_AAAA then 0x5555_5555).
  - Second m_valid_o rises exactly 1 cycle after the first DONE.
  - Each returned value is correct.

Source files
------------

// File: rtl/rib_ex_bridge_pkg.sv
// rib_ex_bridge_pkg: shared definitions for the execute-port to valid/ready bridge.
// Holds the FSM state encodings and the default bus widths, which follow the
// core's memory bus width macros when those are already defined.

`ifndef RIB_MEM_ADDR_W
`define RIB_MEM_ADDR_W 32
`endif
`ifndef RIB_MEM_DATA_W
`define RIB_MEM_DATA_W 32
`endif

package rib_ex_bridge_pkg;

   localparam int RIB_EX_BR_ADDR_W = `RIB_MEM_ADDR_W;
   localparam int RIB_EX_BR_DATA_W = `RIB_MEM_DATA_W;

   typedef enum logic [1:0] {
      RIB_EX_BR_IDLE   = 2'd0,
      RIB_EX_BR_ACCESS = 2'd1,
      RIB_EX_BR_DONE   = 2'd2
   } rib_ex_br_state_t;

   // Width of a counter that must be able to hold the value 'limit'.
   function automatic int rib_ex_br_cnt_w(input int limit);
      if (limit < 1) return 1;
      return $clog2(limit + 1);
   endfunction

endpackage

// File: rtl/rib_ex_bridge.sv
// rib_ex_bridge: adapts the core's same-cycle execute memory port to a
// wait-stated valid/ready slave bus. The core is stalled via hold_o from the
// request cycle until the slave answers, then the captured read data is shown
// for one cycle with hold released so the execute stage retires the access.
//
// Optional feature (macro RIB_EX_BRIDGE_TIMEOUT_EN): an ACCESS-state watchdog
// that abandons the slave access after TIMEOUT_CYCLES cycles, returns zero data
// and pulses err_o. Without the macro ACCESS waits indefinitely and err_o is 0.

import rib_ex_bridge_pkg::*;

module rib_ex_bridge #(
   parameter int ADDR_W         = RIB_EX_BR_ADDR_W,
   parameter int DATA_W         = RIB_EX_BR_DATA_W,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] ex_addr_i,
   input  logic [DATA_W-1:0] ex_data_i,
   input  logic              ex_req_i,
   input  logic              ex_we_i,
   output logic [DATA_W-1:0] ex_data_o,
   output logic              hold_o,
   output logic              m_valid_o,
   input  logic              m_ready_i,
   output logic [ADDR_W-1:0] m_addr_o,
   output logic [DATA_W-1:0] m_wdata_o,
   output logic              m_we_o,
   input  logic [DATA_W-1:0] m_rdata_i,
   output logic              err_o
);

   rib_ex_br_state_t    r_state;
   logic                r_valid;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic                r_we;
   logic [DATA_W-1:0]   r_rdata;
   logic                w_handshake;

   assign w_handshake = r_valid & m_ready_i;

`ifdef RIB_EX_BRIDGE_TIMEOUT_EN
   localparam int CNT_W = rib_ex_br_cnt_w(TIMEOUT_CYCLES);

   logic [CNT_W-1:0]    r_cnt;
   logic                r_err;
   logic                w_timeout;

   // The limit is hit in the ACCESS cycle whose count is TIMEOUT_CYCLES-1, so
   // m_valid_o is up for exactly TIMEOUT_CYCLES cycles; a ready in that same
   // cycle takes priority.
   assign w_timeout = (r_state == RIB_EX_BR_ACCESS) && !m_ready_i &&
                      (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
   assign err_o     = r_err;
`else
   assign err_o     = 1'b0;
`endif

   // Stall the core combinationally in the request cycle and throughout ACCESS;
   // DONE releases it so the registered data is consumed.
   assign hold_o    = (r_state == RIB_EX_BR_ACCESS) ||
                      ((r_state == RIB_EX_BR_IDLE) && ex_req_i);

   assign ex_data_o = r_rdata;
   assign m_valid_o = r_valid;
   assign m_addr_o  = r_addr;
   assign m_wdata_o = r_wdata;
   assign m_we_o    = r_we;

   // Bridge FSM with registered slave payload, valid, read data and error pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= RIB_EX_BR_IDLE;
         r_valid <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_we    <= 1'b0;
         r_rdata <= '0;
`ifdef RIB_EX_BRIDGE_TIMEOUT_EN
         r_cnt   <= '0;
         r_err   <= 1'b0;
`endif
      end else begin
`ifdef RIB_EX_BRIDGE_TIMEOUT_EN
         r_err <= 1'b0;
`endif
         case (r_state)
            RIB_EX_BR_IDLE: begin
               // ex_* are only sampled here; they are ignored in other states.
               if (ex_req_i) begin
                  r_addr  <= ex_addr_i;
                  r_wdata <= ex_data_i;
                  r_we    <= ex_we_i;
                  r_valid <= 1'b1;
`ifdef RIB_EX_BRIDGE_TIMEOUT_EN
                  r_cnt   <= '0;
`endif
                  r_state <= RIB_EX_BR_ACCESS;
               end
            end

            RIB_EX_BR_ACCESS: begin
               // The slave access always runs to completion even if the core
               // withdraws its request; the core discards the result itself.
               if (w_handshake) begin
                  r_rdata <= m_rdata_i;
                  r_valid <= 1'b0;
                  r_state <= RIB_EX_BR_DONE;
               end
`ifdef RIB_EX_BRIDGE_TIMEOUT_EN
               else if (w_timeout) begin
                  r_rdata <= '0;
                  r_valid <= 1'b0;
                  r_err   <= 1'b1;
                  r_state <= RIB_EX_BR_DONE;
               end else begin
                  r_cnt   <= r_cnt + 1'b1;
               end
`endif
            end

            RIB_EX_BR_DONE: begin
               r_state <= RIB_EX_BR_IDLE;
            end

            default: begin
               r_valid <= 1'b0;
               r_state <= RIB_EX_BR_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rib_ex_bridge.sv
// tb_rib_ex_bridge: directed scoreboard bench for rib_ex_bridge.
// Stimulus pushes the expected slave payload and returned data into a queue;
// a monitor pops on every slave handshake (or timeout error pulse) and checks.

module tb_rib_ex_bridge;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [AW-1:0] ex_addr_i = '0;
   logic [DW-1:0] ex_data_i = '0;
   logic          ex_req_i  = 1'b0;
   logic          ex_we_i   = 1'b0;
   logic [DW-1:0] ex_data_o;
   logic          hold_o;
   logic          m_valid_o;
   logic          m_ready_i = 1'b0;
   logic [AW-1:0] m_addr_o;
   logic [DW-1:0] m_wdata_o;
   logic          m_we_o;
   logic [DW-1:0] m_rdata_i = '0;
   logic          err_o;

   always #5 clk = ~clk;

   rib_ex_bridge #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst),
      .ex_addr_i(ex_addr_i), .ex_data_i(ex_data_i), .ex_req_i(ex_req_i), .ex_we_i(ex_we_i),
      .ex_data_o(ex_data_o), .hold_o(hold_o),
      .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
      .m_addr_o(m_addr_o), .m_wdata_o(m_wdata_o), .m_we_o(m_we_o),
      .m_rdata_i(m_rdata_i), .err_o(err_o)
   );

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        we;
      logic [31:0] rdata;
      logic        to;
   } exp_t;

   typedef struct {
      int          wt;
      logic [31:0] rd;
   } sl_t;

   exp_t exp_q[$];
   sl_t  sl_q[$];
   int   total = 0;
   int   bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, req);
      end
   endtask

   // Slave model: per transaction, waits 'wt' valid cycles then asserts ready.
   initial begin
      bit  act = 0;
      int  cnt = 0;
      sl_t cur;
      cur.wt = 1000;
      cur.rd = 32'hDEAD_BEEF;
      forever begin
         @(posedge clk);
         #1;
         if (m_valid_o) begin
            if (!act) begin
               act = 1;
               cnt = 0;
               if (sl_q.size() > 0) cur = sl_q.pop_front();
               else begin
                  cur.wt = 1000;
                  cur.rd = 32'hDEAD_BEEF;
               end
            end
            m_ready_i = (cnt == cur.wt);
            m_rdata_i = m_ready_i ? cur.rd : 32'h0BAD_0BAD;
            cnt++;
         end else begin
            act = 0;
            m_ready_i = 1'b0;
         end
      end
   end

   // Monitor: checks payload on handshake, returned data in the following
   // DONE cycle, timeout completions on err_o, and payload stability.
   initial begin
      logic          prev_v = 1'b0;
      logic [31:0]   prev_a = '0;
      logic [31:0]   prev_d = '0;
      logic          prev_w = 1'b0;
      bit            pend   = 0;
      exp_t          pe;
      forever begin
         @(negedge clk);
         if (pend) begin
            chk("done_hold", 32'(hold_o), 32'd0);
            chk("done_rdata", ex_data_o, pe.rdata);
            chk("done_err", 32'(err_o), 32'd0);
            pend = 0;
         end
         if (err_o) begin
            if (exp_q.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_err: got err_o=1 want no pending access");
            end else begin
               pe = exp_q.pop_front();
               chk("to_expected", 32'(pe.to), 32'd1);
               chk("to_rdata", ex_data_o, 32'd0);
               chk("to_hold", 32'(hold_o), 32'd0);
            end
         end
         if (m_valid_o && prev_v) begin
            chk("stable_addr", m_addr_o, prev_a);
            chk("stable_wdata", m_wdata_o, prev_d);
            chk("stable_we", 32'(m_we_o), 32'(prev_w));
         end
         if (m_valid_o && m_ready_i) begin
            if (exp_q.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_txn: got handshake addr %h want none", m_addr_o);
            end else begin
               pe = exp_q.pop_front();
               chk("hs_addr", m_addr_o, pe.addr);
               chk("hs_wdata", m_wdata_o, pe.wdata);
               chk("hs_we", 32'(m_we_o), 32'(pe.we));
               chk("hs_not_to", 32'(pe.to), 32'd0);
               pend = 1;
            end
         end
         prev_v = m_valid_o;
         prev_a = m_addr_o;
         prev_d = m_wdata_o;
         prev_w = m_we_o;
      end
   end

   // One access from IDLE: req stays high for req_cyc accepted edges; checks
   // hold/valid cycle counts and that DONE is reached in bounded time.
   task automatic access(input logic [31:0] addr, input logic [31:0] wdata, input logic we,
                         input logic [31:0] rdata, input int wt, input int req_cyc,
                         input bit to, input int exp_hold, input int exp_valid);
      int hc = 0;
      int vc = 0;
      bit done = 0;
      exp_t e;
      sl_t  s;
      s.wt = wt; s.rd = rdata;
      sl_q.push_back(s);
      e.addr = addr; e.wdata = wdata; e.we = we; e.rdata = to ? 32'd0 : rdata; e.to = to;
      exp_q.push_back(e);
      ex_addr_i = addr; ex_data_i = wdata; ex_we_i = we; ex_req_i = 1'b1;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (hold_o) hc++;
         if (m_valid_o) vc++;
         if (!hold_o) begin
            done = 1;
            break;
         end
         @(posedge clk);
         #1;
         if (c + 1 >= req_cyc) ex_req_i = 1'b0;
      end
      ex_req_i = 1'b0;
      chk("done_reached", 32'(done), 32'd1);
      chk("hold_cycles", 32'(hc), 32'(exp_hold));
      chk("valid_cycles", 32'(vc), 32'(exp_valid));
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish want finish before 200000");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [5:0] vt;
      logic [5:0] ht;
      sl_t        s;
      exp_t       e;

      // Reset state while rst is held low.
      repeat (2) @(negedge clk);
      chk("rst_valid", 32'(m_valid_o), 32'd0);
      chk("rst_hold", 32'(hold_o), 32'd0);
      chk("rst_exdata", ex_data_o, 32'd0);
      chk("rst_addr", m_addr_o, 32'd0);
      chk("rst_wdata", m_wdata_o, 32'd0);
      chk("rst_we", 32'(m_we_o), 32'd0);
      chk("rst_err", 32'(err_o), 32'd0);
      #2 rst = 1'b1;
      @(posedge clk);
      #1;

      // Zero-wait read.
      access(32'h1000_0004, 32'h0, 1'b0, 32'hCAFE_F00D, 0, 1, 1'b0, 2, 1);
      // Write with 5 wait states.
      access(32'h2000_0000, 32'h1234_5678, 1'b1, 32'h0000_0077, 5, 1, 1'b0, 7, 6);
      // Request dropped after one ACCESS cycle, ready on the 3rd valid cycle.
      access(32'h3000_0010, 32'h0, 1'b0, 32'h1357_9BDF, 2, 2, 1'b0, 4, 3);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("no_spurious_valid", 32'(m_valid_o), 32'd0);
      end
      @(posedge clk);
      #1;

      // Back-to-back with ex_req_i held high across two accesses.
      s.wt = 0; s.rd = 32'hAAAA_AAAA; sl_q.push_back(s);
      s.wt = 0; s.rd = 32'h5555_5555; sl_q.push_back(s);
      e.addr = 32'h4000_0000; e.wdata = 32'h0; e.we = 1'b0; e.rdata = 32'hAAAA_AAAA; e.to = 1'b0;
      exp_q.push_back(e);
      e.rdata = 32'h5555_5555;
      exp_q.push_back(e);
      ex_addr_i = 32'h4000_0000; ex_data_i = 32'h0; ex_we_i = 1'b0; ex_req_i = 1'b1;
      vt = '0; ht = '0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         vt = {vt[4:0], m_valid_o};
         ht = {ht[4:0], hold_o};
         @(posedge clk);
         #1;
         if (i == 3) ex_req_i = 1'b0;
      end
      chk("b2b_valid_trace", 32'(vt), 32'(6'b010010));
      chk("b2b_hold_trace", 32'(ht), 32'(6'b110110));

      // Asynchronous reset in the middle of a stalled write.
      s.wt = 1000; s.rd = 32'hFFFF_FFFF; sl_q.push_back(s);
      ex_addr_i = 32'h5000_0000; ex_data_i = 32'hA5A5_A5A5; ex_we_i = 1'b1; ex_req_i = 1'b1;
      @(posedge clk);
      #1;
      ex_req_i = 1'b0;
      repeat (2) @(negedge clk);
      chk("pre_rst_valid", 32'(m_valid_o), 32'd1);
      #1 rst = 1'b0;
      #1;
      chk("arst_valid", 32'(m_valid_o), 32'd0);
      chk("arst_hold", 32'(hold_o), 32'd0);
      chk("arst_exdata", ex_data_o, 32'd0);
      chk("arst_addr", m_addr_o, 32'd0);
      chk("arst_we", 32'(m_we_o), 32'd0);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("post_rst_idle_valid", 32'(m_valid_o), 32'd0);
      chk("post_rst_idle_hold", 32'(hold_o), 32'd0);
      @(posedge clk);
      #1;

`ifdef RIB_EX_BRIDGE_TIMEOUT_EN
      // Slave never answers: 4 valid cycles, then err_o with zero data.
      access(32'h6000_0000, 32'h0, 1'b0, 32'h0, 1000, 1, 1'b1, 5, 4);
      // Ready on the limit cycle wins.
      access(32'h6000_0004, 32'h0, 1'b0, 32'h600D_D00D, 3, 1, 1'b0, 5, 4);
`endif

      // Final read to confirm normal operation after everything above.
      access(32'h7000_0008, 32'h0, 1'b0, 32'h89AB_CDEF, 1, 1, 1'b0, 3, 2);

      @(negedge clk);
      chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
